// File: rtl/mult_result_accum.sv
// mult_result_accum: sums the four signed products of each sample, accumulates
// ACC_LEN consecutive sums into one block value, and presents it over a
// valid/ready handshake.
// Optional build macro MULT_ACC_SAT_EN: saturate the block value to OUT_W bits
// and report clipping on Sat_Flag. Without it the value wraps and Sat_Flag is 0.
module mult_result_accum #(
    parameter int IN_W    = 16,
    parameter int ACC_LEN = 16,
    parameter int OUT_W   = 24
) (
    input  logic                    Clock,
    input  logic                    Rst,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic signed [IN_W-1:0]  Result0,
    input  logic signed [IN_W-1:0]  Result1,
    input  logic signed [IN_W-1:0]  Result2,
    input  logic signed [IN_W-1:0]  Result3,
    output logic signed [OUT_W-1:0] Acc_Out,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic                    Sat_Flag,
    output logic [7:0]              Blk_Cnt
);

    localparam int         S1_W     = IN_W + 2;
    localparam int         ACC_W    = S1_W + $clog2(ACC_LEN);
    localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

    logic signed [S1_W-1:0]  in_sum;
    logic signed [S1_W-1:0]  s1_sum;
    logic                    s1_valid;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] s1_ext;
    logic signed [ACC_W-1:0] next_acc;
    logic signed [OUT_W-1:0] fit_val;
    logic                    fit_clip;
    logic                    blk_last;
    logic                    stall;
    logic                    accept;
    logic                    advance;

    // Exact 4-way sum of the incoming sample and the next accumulator value
    always_comb begin
        in_sum = {{2{Result0[IN_W-1]}}, Result0}
               + {{2{Result1[IN_W-1]}}, Result1}
               + {{2{Result2[IN_W-1]}}, Result2}
               + {{2{Result3[IN_W-1]}}, Result3};
        acc_base = (Blk_Cnt == '0) ? '0 : acc;
        s1_ext   = {{(ACC_W-S1_W){s1_sum[S1_W-1]}}, s1_sum};
        next_acc = acc_base + s1_ext;
    end

    // Pipeline control: a finished block cannot be overwritten while the
    // previous one is still waiting for the consumer
    always_comb begin
        blk_last = (Blk_Cnt == LAST_CNT);
        stall    = s1_valid && blk_last && Out_Valid && !Out_Ready;
        In_Ready = !stall;
        accept   = In_Valid && !stall;
        advance  = s1_valid && !stall;
    end

    generate
        if (OUT_W >= ACC_W) begin : g_fit_extend
            // Output is wide enough: plain sign extension, never clips
            always_comb begin
                fit_val  = OUT_W'(next_acc);
                fit_clip = 1'b0;
            end
        end else begin : g_fit_narrow
`ifdef MULT_ACC_SAT_EN
            logic [ACC_W-OUT_W:0] top_bits;
            // Saturate when the bits above the output sign bit disagree
            always_comb begin
                top_bits = next_acc[ACC_W-1:OUT_W-1];
                fit_clip = !((&top_bits) || !(|top_bits));
                if (fit_clip) begin
                    fit_val = next_acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                : {1'b0, {(OUT_W-1){1'b1}}};
                end else begin
                    fit_val = next_acc[OUT_W-1:0];
                end
            end
`else
            // Two's-complement wrap: keep the low OUT_W bits
            always_comb begin
                fit_val  = next_acc[OUT_W-1:0];
                fit_clip = 1'b0;
            end
`endif
        end
    endgenerate

    // Stage 1: register the summed sample; drains once stage 2 takes it
    always_ff @(posedge Clock) begin
        if (Rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (accept) begin
            s1_sum   <= in_sum;
            s1_valid <= 1'b1;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: block accumulator and in-block sample counter
    always_ff @(posedge Clock) begin
        if (Rst) begin
            acc     <= '0;
            Blk_Cnt <= '0;
        end else if (advance) begin
            acc     <= next_acc;
            Blk_Cnt <= blk_last ? '0 : Blk_Cnt + 8'd1;
        end
    end

    // Output register: load on block end, clear on handshake, otherwise hold
    always_ff @(posedge Clock) begin
        if (Rst) begin
            Acc_Out   <= '0;
            Out_Valid <= 1'b0;
            Sat_Flag  <= 1'b0;
        end else if (advance && blk_last) begin
            Acc_Out   <= fit_val;
            Out_Valid <= 1'b1;
            Sat_Flag  <= fit_clip;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_result_accum.sv
// tb_mult_result_accum: directed stimulus for two configurations of
// mult_result_accum (ACC_LEN=4/OUT_W=24 and ACC_LEN=16/OUT_W=18) with a
// block-level reference model for the first one.
module tb_mult_result_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: ACC_LEN=4, OUT_W=24 (never clips)
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] r0, r1, r2, r3;
    logic signed [23:0] acc_out;
    logic               out_valid;
    logic               out_ready;
    logic               sat_flag;
    logic [7:0]         blk_cnt;

    // Instance B: ACC_LEN=16, OUT_W=18 (clips/wraps)
    logic               in_valid_b;
    logic               in_ready_b;
    logic signed [15:0] rb;
    logic signed [17:0] acc_out_b;
    logic               out_valid_b;
    logic               out_ready_b;
    logic               sat_flag_b;
    logic [7:0]         blk_cnt_b;

    mult_result_accum #(.IN_W(16), .ACC_LEN(4), .OUT_W(24)) dut_a (
        .Clock(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready),
        .Result0(r0), .Result1(r1), .Result2(r2), .Result3(r3),
        .Acc_Out(acc_out), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Sat_Flag(sat_flag), .Blk_Cnt(blk_cnt)
    );

    mult_result_accum #(.IN_W(16), .ACC_LEN(16), .OUT_W(18)) dut_b (
        .Clock(clk), .Rst(rst), .In_Valid(in_valid_b), .In_Ready(in_ready_b),
        .Result0(rb), .Result1(rb), .Result2(rb), .Result3(rb),
        .Acc_Out(acc_out_b), .Out_Valid(out_valid_b), .Out_Ready(out_ready_b),
        .Sat_Flag(sat_flag_b), .Blk_Cnt(blk_cnt_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b, input int c, input int d);
        in_valid = v;
        r0 = 16'(a);
        r1 = 16'(b);
        r2 = 16'(c);
        r3 = 16'(d);
    endtask

    // Reference model for instance A: every accepted sample's 4-way sum is
    // added to a running block total; every 4th accepted sample closes a block
    // whose value joins the queue of results the consumer must receive in order.
    int                 q[$];
    int                 partial = 0;
    int                 pcount  = 0;
    logic               prev_hold = 1'b0;
    logic signed [23:0] prev_acc  = '0;

    always @(negedge clk) begin
        if (prev_hold) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_acc_out", acc_out, prev_acc);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                check("model_acc_out", acc_out, q[0]);
                check("model_sat_flag", sat_flag, 0);
            end
        end
        prev_hold = out_valid && !out_ready && !rst;
        prev_acc  = acc_out;
        if (rst) begin
            q.delete();
            partial = 0;
            pcount  = 0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                partial += int'(r0) + int'(r1) + int'(r2) + int'(r3);
                pcount++;
                if (pcount == 4) begin
                    q.push_back(partial);
                    partial = 0;
                    pcount  = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  idx;
        logic acc_now;
        longint exp_b;
        longint exp_sat_b;

        // Reset held for 2 cycles with In_Valid asserted
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1, 7, 7, 7, 7);
        in_valid_b = 1'b0;
        rb = '0;
        out_ready_b = 1'b1;
        tick();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        check("rst_sat_flag", sat_flag, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_in_ready_after", in_ready, 1);
        check("rst_out_valid_after", out_valid, 0);
        check("rst_b_out_valid", out_valid_b, 0);
        tick();

        // Basic block: 4 samples of {100,-20,5,15} -> 400 in cycle 5
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1, 100, -20, 5, 15);
            else       drive(0, 0, 0, 0, 0);
            @(negedge clk);
            check("basic_in_ready", in_ready, 1);
            check("basic_out_valid", out_valid, (c == 5));
            if (c == 5) begin
                check("basic_acc_out", acc_out, 400);
                check("basic_sat_flag", sat_flag, 0);
                check("basic_blk_cnt_wrap", blk_cnt, 0);
            end
            if (c == 2) check("basic_blk_cnt_1", blk_cnt, 1);
            if (c == 4) check("basic_blk_cnt_3", blk_cnt, 3);
            tick();
        end

        // Back-to-back: 8 samples of {1,1,1,1} -> 16 in cycles 5 and 9
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(1, 1, 1, 1, 1);
            else       drive(0, 0, 0, 0, 0);
            @(negedge clk);
            check("b2b_in_ready", in_ready, 1);
            check("b2b_out_valid", out_valid, (c == 5 || c == 9));
            if (c == 5 || c == 9) check("b2b_acc_out", acc_out, 16);
            tick();
        end

        // Back-pressure: sample k carries {k+1,0,0,0}; consumer stalls until cycle 12.
        // Blocks: 1+2+3+4=10, 5+6+7+8=26, 9+10+11+12=42.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 12);
            if (idx < 12) drive(1, idx + 1, 0, 0, 0);
            else          drive(0, 0, 0, 0, 0);
            @(negedge clk);
            check("bp_in_ready", in_ready, !(c >= 8 && c <= 11));
            if (c >= 5 && c <= 12) begin
                check("bp_out_valid_blk1", out_valid, 1);
                check("bp_acc_out_blk1", acc_out, 10);
            end
            if (c == 13) begin
                check("bp_out_valid_blk2", out_valid, 1);
                check("bp_acc_out_blk2", acc_out, 26);
            end
            if (c == 14 || c == 18) check("bp_out_valid_gap", out_valid, 0);
            if (c == 17) begin
                check("bp_out_valid_blk3", out_valid, 1);
                check("bp_acc_out_blk3", acc_out, 42);
            end
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) idx++;
        end
        check("bp_all_samples_taken", idx, 12);

        // Mid-block reset: partial 80 discarded, then 4 x {1,0,0,0} -> 4 in cycle 8
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rst = (c == 2);
            if (c < 2)                drive(1, 10, 10, 10, 10);
            else if (c >= 3 && c < 7) drive(1, 1, 0, 0, 0);
            else                      drive(0, 0, 0, 0, 0);
            @(negedge clk);
            check("mrst_out_valid", out_valid, (c == 8));
            if (c == 8) check("mrst_acc_out", acc_out, 4);
            if (c == 3) check("mrst_blk_cnt", blk_cnt, 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);

        // Saturation/wrap on instance B: 16 samples of {16129 x4}, total 1032256
`ifdef MULT_ACC_SAT_EN
        exp_b     = 131071;
        exp_sat_b = 1;
`else
        exp_b     = 245824;
        exp_sat_b = 0;
`endif
        for (int c = 0; c < 20; c++) begin
            in_valid_b = (c < 16);
            rb = (c < 16) ? 16'sd16129 : 16'sd0;
            @(negedge clk);
            check("sat_in_ready", in_ready_b, 1);
            check("sat_out_valid", out_valid_b, (c == 17));
            if (c == 17) begin
                check("sat_acc_out", longint'($unsigned(acc_out_b)), exp_b);
                check("sat_flag", sat_flag_b, exp_sat_b);
            end
            tick();
        end
        in_valid_b = 1'b0;

        tick();
        @(negedge clk);
        check("model_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
